// File: rtl/batch_bank_if.sv
// Handshake bundle between the batch bank controller and its stream source,
// stream sink and sample_ctrl. The controller uses the master modport.
interface batch_bank_if #(
  parameter int AW    = 12,
  parameter int NBANK = 2
);
  localparam int BW = $clog2(NBANK);

  // Source stream (fill side)
  logic          src_valid;
  logic          src_last;
  logic          src_ready;
  logic          src_v;
  logic [AW-1:0] src_a;
  logic [BW-1:0] src_bank;

  // Compute handshake with sample_ctrl
  logic          s_init;
  logic [BW-1:0] s_bank;
  logic          s_fin;

  // Result stream (drain side)
  logic          dst_valid;
  logic          dst_ready;
  logic          dst_v;
  logic [AW-1:0] dst_a;
  logic [BW-1:0] dst_bank;
  logic          dst_last;

  modport master (
    input  src_valid, src_last, s_fin, dst_ready,
    output src_ready, src_v, src_a, src_bank,
    output s_init, s_bank,
    output dst_valid, dst_v, dst_a, dst_bank, dst_last
  );

  modport slave (
    output src_valid, src_last, s_fin, dst_ready,
    input  src_ready, src_v, src_a, src_bank,
    input  s_init, s_bank,
    input  dst_valid, dst_v, dst_a, dst_bank, dst_last
  );
endinterface

// File: rtl/batch_bank_ctrl.sv
// Ping-pong batch sequencer: fills NBANK input banks from the source stream,
// hands each full bank to compute in order, then drains that bank's results.
// Fill, compute and drain run concurrently on different banks.
module batch_bank_ctrl #(
  parameter int AW    = 12,
  parameter int NBANK = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [AW-1:0] ss,
  input  logic [AW-1:0] ds,
  output logic          err_last,
  batch_bank_if.master  bus
);
  localparam int BW = $clog2(NBANK);

  // Banks always advance FREE -> FULL -> BUSY -> DONE -> FREE; the partially
  // filled bank stays FREE until its last word lands.
  typedef enum logic [1:0] {
    B_FREE,
    B_FULL,
    B_BUSY,
    B_DONE
  } bank_st_e;

  bank_st_e      bank_st [NBANK];
  logic [BW-1:0] wp, cp, dp;
  logic [BW:0]   used;
  logic [AW-1:0] src_a_q, dst_a_q;
  logic          src_rdy_q;
  logic          busy;
  logic          s_init_q;
  logic          dst_valid_q;

  logic          src_v, fill_done;
  logic          dst_v, drain_done;
  logic [BW-1:0] dp_inc;
  logic [BW:0]   used_nxt;

  assign src_v      = bus.src_valid & src_rdy_q & run;
  assign fill_done  = src_v & (src_a_q == ss);
  assign dst_v      = dst_valid_q & bus.dst_ready;
  assign drain_done = dst_v & (dst_a_q == ds);
  assign dp_inc     = dp + 1'b1;
  // A bank completing and a bank draining in the same cycle cancel out.
  assign used_nxt   = used + {{BW{1'b0}}, fill_done} - {{BW{1'b0}}, drain_done};

  assign bus.src_ready = src_rdy_q & run;
  assign bus.src_v     = src_v;
  assign bus.src_a     = src_a_q;
  assign bus.src_bank  = wp;
  assign bus.s_init    = s_init_q;
  assign bus.s_bank    = cp;
  assign bus.dst_valid = dst_valid_q;
  assign bus.dst_v     = dst_v;
  assign bus.dst_a     = dst_a_q;
  assign bus.dst_bank  = dp;
  assign bus.dst_last  = dst_valid_q & (dst_a_q == ds);

  // Bank state machine plus fill, compute and drain pointers.
  // NOTE: all state uses non-blocking assignments so every branch below reads
  // the pre-edge values; fill, compute and drain then update independently.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      wp          <= '0;
      cp          <= '0;
      dp          <= '0;
      used        <= '0;
      src_a_q     <= '0;
      dst_a_q     <= '0;
      src_rdy_q   <= 1'b0;
      busy        <= 1'b0;
      s_init_q    <= 1'b0;
      dst_valid_q <= 1'b0;
      // NOTE: the bank state array is only NBANK two-bit entries and must
      // start FREE, so it is reset like ordinary flops (it is not a RAM).
      for (int i = 0; i < NBANK; i++) bank_st[i] <= B_FREE;
      // Dropping run discards the batch but keeps the protocol error visible.
      if (rst) err_last <= 1'b0;
    end else begin
      used      <= used_nxt;
      src_rdy_q <= (used_nxt < (BW+1)'(NBANK));

      // Fill: count words, the count alone decides the bank boundary.
      if (src_v) begin
        if (bus.src_last != (src_a_q == ss)) err_last <= 1'b1;
        if (src_a_q == ss) begin
          src_a_q     <= '0;
          bank_st[wp] <= B_FULL;
          wp          <= wp + 1'b1;
        end else begin
          src_a_q <= src_a_q + 1'b1;
        end
      end

      // Compute: one bank at a time, in fill order; s_fin while idle is ignored.
      s_init_q <= 1'b0;
      if (!busy) begin
        if (bank_st[cp] == B_FULL) begin
          s_init_q    <= 1'b1;
          busy        <= 1'b1;
          bank_st[cp] <= B_BUSY;
        end
      end else if (bus.s_fin) begin
        bank_st[cp] <= B_DONE;
        cp          <= cp + 1'b1;
        busy        <= 1'b0;
      end

      // Drain: stream continues straight into the next bank if it is done.
      if (drain_done) begin
        dst_a_q     <= '0;
        dp          <= dp_inc;
        bank_st[dp] <= B_FREE;
        dst_valid_q <= (bank_st[dp_inc] == B_DONE);
      end else if (dst_v) begin
        dst_a_q <= dst_a_q + 1'b1;
      end else if (!dst_valid_q) begin
        dst_valid_q <= (bank_st[dp] == B_DONE);
      end
    end
  end
endmodule

// File: tb/tb_batch_bank_ctrl.sv
// Directed bench for batch_bank_ctrl: a two-bank instance (ss=3, ds=1) for
// fill/compute/drain, overlap, back-pressure, src_last error and run drop, and
// a four-bank instance with single-word banks.
module tb_batch_bank_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_a = 1'b1;
  logic        run_b = 1'b1;
  logic [11:0] ss_a = 12'd3, ds_a = 12'd1;
  logic [11:0] ss_b = 12'd0, ds_b = 12'd0;
  logic        err_a, err_b;

  int checks = 0;
  int failures = 0;
  int n;
  int bad;
  int b_cnt = 0;
  int b_ord_err = 0;

  always #5 clk = ~clk;

  batch_bank_if #(.AW(12), .NBANK(2)) ia ();
  batch_bank_if #(.AW(12), .NBANK(4)) ib ();

  batch_bank_ctrl #(.AW(12), .NBANK(2)) u_a (
    .clk(clk), .rst(rst), .run(run_a), .ss(ss_a), .ds(ds_a),
    .err_last(err_a), .bus(ia.master)
  );

  batch_bank_ctrl #(.AW(12), .NBANK(4)) u_b (
    .clk(clk), .rst(rst), .run(run_b), .ss(ss_b), .ds(ds_b),
    .err_last(err_b), .bus(ib.master)
  );

  // Result beats of the four-bank instance must leave in bank order 0,1,2,3.
  always @(posedge clk) begin
    if (ib.dst_v) begin
      if (ib.dst_bank != b_cnt[1:0]) b_ord_err++;
      b_cnt++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ia.src_valid = 0; ia.src_last = 0; ia.s_fin = 0; ia.dst_ready = 1;
    ib.src_valid = 0; ib.src_last = 0; ib.s_fin = 0; ib.dst_ready = 1;

    // ---------------- reset state
    step(); step();
    check("rst_src_ready", ia.src_ready, 0);
    check("rst_src_a", ia.src_a, 0);
    check("rst_dst_valid", ia.dst_valid, 0);
    check("rst_s_init", ia.s_init, 0);
    check("rst_err_last", err_a, 0);
    check("rst_b_src_ready", ib.src_ready, 0);
    rst = 0;
    step();
    check("post_rst_src_ready", ia.src_ready, 1);

    // ---------------- basic fill -> compute -> drain
    for (int i = 0; i < 4; i++) begin
      ia.src_valid = 1; ia.src_last = (i == 3);
      #1;
      check("fill_src_a", ia.src_a, i);
      check("fill_src_v", ia.src_v, 1);
      step();
    end
    ia.src_valid = 0; ia.src_last = 0;
    check("init_t1", ia.s_init, 0);
    step();
    check("init_t2", ia.s_init, 1);
    check("init_bank", ia.s_bank, 0);
    check("fill_bank_next", ia.src_bank, 1);
    step();
    check("init_pulse_end", ia.s_init, 0);
    ia.s_fin = 1; step(); ia.s_fin = 0;
    n = 0;
    while (ia.dst_valid !== 1'b1 && n < 4) begin step(); n++; end
    check("drain_start_seen", int'(n < 4), 1);
    check("drain_a0", ia.dst_a, 0);
    check("drain_bank0", ia.dst_bank, 0);
    check("drain_last0", ia.dst_last, 0);
    step();
    check("drain_a1", ia.dst_a, 1);
    check("drain_last1", ia.dst_last, 1);
    step();
    check("drain_end_valid", ia.dst_valid, 0);

    // ---------------- overlap: 8 beats back-to-back, compute held off
    rst = 1; step(); rst = 0; step();
    for (int i = 0; i < 8; i++) begin
      ia.src_valid = 1; ia.src_last = ((i % 4) == 3);
      #1;
      check("ovl_src_ready", ia.src_ready, 1);
      check("ovl_s_init", ia.s_init, int'(i == 5));
      if (i == 5) check("ovl_s_bank0", ia.s_bank, 0);
      step();
    end
    ia.src_valid = 0; ia.src_last = 0;
    check("ovl_full_ready", ia.src_ready, 0);
    bad = 0;
    repeat (20) begin
      step();
      if (ia.src_ready !== 1'b0 || ia.s_init !== 1'b0) bad++;
    end
    check("ovl_hold_quiet", bad, 0);
    ia.dst_ready = 0;
    ia.s_fin = 1; step(); ia.s_fin = 0;
    step();
    check("ovl_s_init1", ia.s_init, 1);
    check("ovl_s_bank1", ia.s_bank, 1);
    check("ovl_dst_valid", ia.dst_valid, 1);
    check("ovl_dst_bank", ia.dst_bank, 0);

    // ---------------- back-pressure
    bad = 0;
    repeat (5) begin
      step();
      if (ia.dst_valid !== 1'b1 || ia.dst_a !== 12'd0 || ia.src_ready !== 1'b0) bad++;
    end
    check("bp_hold_a0", bad, 0);
    ia.dst_ready = 1;
    #1;
    check("bp_dst_v", ia.dst_v, 1);
    step();
    ia.dst_ready = 0;
    bad = 0;
    repeat (5) begin
      step();
      if (ia.dst_valid !== 1'b1 || ia.dst_a !== 12'd1 || ia.dst_last !== 1'b1 ||
          ia.src_ready !== 1'b0) bad++;
    end
    check("bp_hold_a1", bad, 0);
    ia.dst_ready = 1;
    step();
    check("bp_done_valid", ia.dst_valid, 0);
    check("bp_done_ready", ia.src_ready, 1);

    // ---------------- src_last mismatch
    rst = 1; step(); rst = 0; step();
    for (int i = 0; i < 4; i++) begin
      ia.src_valid = 1; ia.src_last = (i == 2);
      #1;
      check("err_progress", err_a, int'(i == 3));
      step();
    end
    ia.src_valid = 0; ia.src_last = 0;
    check("err_sticky", err_a, 1);
    step();
    check("err_bank_done_init", ia.s_init, 1);
    check("err_bank_done_sbank", ia.s_bank, 0);

    // ---------------- run dropped mid-fill at src_a=2
    for (int i = 0; i < 2; i++) begin
      ia.src_valid = 1; step();
    end
    check("runlo_pre_a", ia.src_a, 2);
    run_a = 0;
    #1;
    check("runlo_src_v", ia.src_v, 0);
    check("runlo_ready_now", ia.src_ready, 0);
    step();
    check("runlo_src_a", ia.src_a, 0);
    check("runlo_bank", ia.src_bank, 0);
    check("runlo_err_kept", err_a, 1);
    step();
    check("runlo_ready_hold", ia.src_ready, 0);
    check("runlo_no_init", ia.s_init, 0);
    ia.src_valid = 0;
    run_a = 1;
    step();
    check("runhi_ready", ia.src_ready, 1);
    for (int i = 0; i < 4; i++) begin
      ia.src_valid = 1; ia.src_last = (i == 3);
      #1;
      check("runhi_src_a", ia.src_a, i);
      step();
    end
    ia.src_valid = 0; ia.src_last = 0;
    step();
    check("runhi_init", ia.s_init, 1);
    check("runhi_sbank", ia.s_bank, 0);
    rst = 1; step(); rst = 0;
    check("rst_clears_err", err_a, 0);
    step();

    // s_fin while compute idle must not produce any result beats
    ia.s_fin = 1; step(); ia.s_fin = 0;
    step(); step();
    check("idle_sfin_dst", ia.dst_valid, 0);
    check("idle_sfin_init", ia.s_init, 0);

    // ---------------- NBANK=4, single-word banks
    for (int i = 0; i < 4; i++) begin
      ib.src_valid = 1; ib.src_last = 1;
      #1;
      check("b_src_bank", ib.src_bank, i);
      check("b_src_ready", ib.src_ready, 1);
      check("b_s_init", ib.s_init, int'(i == 2));
      step();
    end
    ib.src_valid = 0; ib.src_last = 0;
    check("b_full_ready", ib.src_ready, 0);
    check("b_err_none", err_b, 0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        n = 0;
        while (ib.s_init !== 1'b1 && n < 8) begin step(); n++; end
        check("b_init_seen", int'(n < 8), 1);
        check("b_s_bank", ib.s_bank, k);
      end else begin
        check("b_ready_before_drain", ib.src_ready, 0);
      end
      ib.s_fin = 1; step(); ib.s_fin = 0;
      if (k == 0) begin
        check("b_ready_still_low", ib.src_ready, 0);
        step();
        check("b_dst_valid", ib.dst_valid, 1);
        check("b_dst_bank", ib.dst_bank, 0);
        check("b_dst_last", ib.dst_last, 1);
      end
      if (k == 1) check("b_ready_after_drain", ib.src_ready, 1);
    end
    repeat (6) step();
    check("b_dst_count", b_cnt, 4);
    check("b_dst_order", b_ord_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
